branch_predictor_2way: RTL

Dual-slot gshare branch predictor for the two-wide superscalar pipeline. Each cycle it supplies taken/not-taken predictions for both fetch slots. It trains a table of 2-bit saturating counters from the branch outcomes resolved in Execute. It restores the global history register (GHR) on a misprediction. It produces the `predictionE1/2` values that the hazard logic later compares against `takenBranch1/2`, and it consumes the same resolution signals.

---
 rtl/bp_pkg.sv | 23 ++
 rtl/bp_counter_table.sv | 51 +++++
 rtl/branch_predictor_2way.sv | 106 ++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the dual-slot gshare branch predictor.
// Holds the 2-bit counter encoding and its saturating update function.
package bp_pkg;

  typedef logic [1:0] bpCtr_t;

  localparam bpCtr_t BP_SNT = 2'b00;
  localparam bpCtr_t BP_WNT = 2'b01;
  localparam bpCtr_t BP_WT  = 2'b10;
  localparam bpCtr_t BP_ST  = 2'b11;

  // Moves the counter one step toward the outcome; it stops at either end.
  function automatic bpCtr_t bp_sat_update(input bpCtr_t counter, input logic taken);
    bpCtr_t result;
    if (taken) begin
      result = (counter == BP_ST) ? BP_ST : bpCtr_t'(counter + 2'd1);
    end else begin
      result = (counter == BP_SNT) ? BP_SNT : bpCtr_t'(counter - 2'd1);
    end
    return result;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of 2-bit saturating counters with two combinational read ports and two write ports.
// When both write ports hit one entry, slot 1 is applied first and slot 2 on top of its result.
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rdIdx1,
  input  logic [INDEX_BITS-1:0] rdIdx2,
  output logic [1:0]            rdCtr1,
  output logic [1:0]            rdCtr2,
  input  logic                  wrEn1,
  input  logic [INDEX_BITS-1:0] wrIdx1,
  input  logic                  wrTaken1,
  input  logic                  wrEn2,
  input  logic [INDEX_BITS-1:0] wrIdx2,
  input  logic                  wrTaken2
);

  localparam int DEPTH = 1 << INDEX_BITS;

  bpCtr_t ctrMem  [DEPTH];
  bpCtr_t nextMem [DEPTH];

  // Reads see the stored value only; a same-cycle write is not bypassed.
  assign rdCtr1 = ctrMem[rdIdx1];
  assign rdCtr2 = ctrMem[rdIdx2];

  always_comb begin
    nextMem = ctrMem;
    if (wrEn1) begin
      nextMem[wrIdx1] = bp_sat_update(nextMem[wrIdx1], wrTaken1);
    end
    if (wrEn2) begin
      nextMem[wrIdx2] = bp_sat_update(nextMem[wrIdx2], wrTaken2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctrMem[i] <= BP_WNT;
      end
    end else begin
      ctrMem <= nextMem;
    end
  end

endmodule

// File: rtl/branch_predictor_2way.sv
// Dual-slot gshare predictor: combinational lookup for two fetch slots, Execute-stage
// training, speculative global history with recovery from the oldest mispredicting slot.
module branch_predictor_2way
  import bp_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PC_WIDTH-1:0]   pcF1,
  input  logic [PC_WIDTH-1:0]   pcF2,
  input  logic                  isBranchF1,
  input  logic                  isBranchF2,
  input  logic                  stallF,
  output logic                  predictionF1,
  output logic                  predictionF2,
  output logic [INDEX_BITS-1:0] indexF1,
  output logic [INDEX_BITS-1:0] indexF2,
  output logic [INDEX_BITS-1:0] ghrF1,
  output logic [INDEX_BITS-1:0] ghrF2,
  input  logic                  branchE1,
  input  logic                  branchE2,
  input  logic                  takenBranch1,
  input  logic                  takenBranch2,
  input  logic                  predictionE1,
  input  logic                  predictionE2,
  input  logic [INDEX_BITS-1:0] indexE1,
  input  logic [INDEX_BITS-1:0] indexE2,
  input  logic [INDEX_BITS-1:0] ghrE1,
  input  logic [INDEX_BITS-1:0] ghrE2,
  output logic                  mispredict
);

  logic [INDEX_BITS-1:0] ghr;
  logic [INDEX_BITS-1:0] ghrNext;
  logic [1:0]            rdCtr1;
  logic [1:0]            rdCtr2;
  logic                  mispE1;
  logic                  mispE2;
  logic                  slot2OnPath;
  logic                  unusedBits;

  // Only the word-index PC bits and the low history bits feed any logic.
  assign unusedBits = ^{pcF1[PC_WIDTH-1:INDEX_BITS+2], pcF1[1:0],
                        pcF2[PC_WIDTH-1:INDEX_BITS+2], pcF2[1:0],
                        ghrE1[INDEX_BITS-1], ghrE2[INDEX_BITS-1]};

  // Slot 2 is indexed with the history as it will look after slot 1's branch shifts in.
  assign ghrF1   = ghr;
  assign ghrF2   = isBranchF1 ? {ghr[INDEX_BITS-2:0], predictionF1} : ghr;
  assign indexF1 = pcF1[INDEX_BITS+1:2] ^ ghrF1;
  assign indexF2 = pcF2[INDEX_BITS+1:2] ^ ghrF2;

  assign predictionF1 = rdCtr1[1];
  assign predictionF2 = rdCtr2[1];

  assign mispE1     = branchE1 & (takenBranch1 ^ predictionE1);
  assign mispE2     = branchE2 & (takenBranch2 ^ predictionE2);
  assign mispredict = mispE1 | mispE2;

  // A predicted-taken branch in slot 1 makes slot 2 off-path.
  assign slot2OnPath = !(isBranchF1 && predictionF1);

  bp_counter_table #(
    .INDEX_BITS(INDEX_BITS)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdIdx1   (indexF1),
    .rdIdx2   (indexF2),
    .rdCtr1   (rdCtr1),
    .rdCtr2   (rdCtr2),
    .wrEn1    (branchE1),
    .wrIdx1   (indexE1),
    .wrTaken1 (takenBranch1),
    .wrEn2    (branchE2),
    .wrIdx2   (indexE2),
    .wrTaken2 (takenBranch2)
  );

  always_comb begin
    ghrNext = ghr;
    if (mispE1) begin
      ghrNext = {ghrE1[INDEX_BITS-2:0], takenBranch1};
    end else if (mispE2) begin
      ghrNext = {ghrE2[INDEX_BITS-2:0], takenBranch2};
    end else if (!stallF) begin
      if (isBranchF1) begin
        ghrNext = {ghrNext[INDEX_BITS-2:0], predictionF1};
      end
      if (isBranchF2 && slot2OnPath) begin
        ghrNext = {ghrNext[INDEX_BITS-2:0], predictionF2};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else begin
      ghr <= ghrNext;
    end
  end

endmodule
